// File: rtl/vx_dcr_launch_ctrl.sv
// Launch sequencer: programs a DCR table into the GPU, waits for busy, measures run length.
// Latency: first DCR write one cycle after start acceptance, then one write per cycle; done one cycle after busy falls.
// Backpressure: cfg/start are accepted only while idle (ready low otherwise); the DCR write port has none.
module vx_dcr_launch_ctrl #(
    parameter int DCR_ADDR_W  = 12,
    parameter int DCR_DATA_W  = 32,
    parameter int NUM_ENTRIES = 8,
    parameter int TIMEOUT     = 1024,
    parameter int CYC_W       = 32,
    localparam int IDX_W      = $clog2(NUM_ENTRIES),
    localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [DCR_ADDR_W-1:0] cfg_addr,
    input  logic [DCR_DATA_W-1:0] cfg_data,
    output logic                  cfg_ready,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_writes,
    output logic                  start_ready,
    output logic                  write_valid,
    output logic [DCR_ADDR_W-1:0] write_addr,
    output logic [DCR_DATA_W-1:0] write_data,
    input  logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [CYC_W-1:0]      run_cycles
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  MAX_N     = CNT_W'(NUM_ENTRIES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, PROG, WAIT_BUSY, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   rdy_q, rdy_d;
    logic [CNT_W-1:0]       n_q, n_d, idx_q, idx_d, n_sel;
    logic [WAIT_W-1:0]      wcnt_q, wcnt_d;
    logic                   wv_d, done_d, terr_d;
    logic [DCR_ADDR_W-1:0]  wa_d, entry0_addr;
    logic [DCR_DATA_W-1:0]  wd_d, entry0_data;
    logic [CYC_W-1:0]       run_d;
    logic [DCR_ADDR_W-1:0]  tbl_addr [NUM_ENTRIES];
    logic [DCR_DATA_W-1:0]  tbl_data [NUM_ENTRIES];
    logic                   cfg_acc, start_acc;

    assign cfg_ready   = rdy_q;
    assign start_ready = rdy_q;
    assign cfg_acc     = cfg_valid && rdy_q;
    assign start_acc   = start && rdy_q;
    assign n_sel       = (num_writes > MAX_N) ? MAX_N : num_writes;

    // Entry 0 is read on the same edge a concurrent cfg write lands, so forward it.
    assign entry0_addr = (cfg_acc && cfg_idx == '0) ? cfg_addr : tbl_addr[0];
    assign entry0_data = (cfg_acc && cfg_idx == '0) ? cfg_data : tbl_data[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
        end else if (cfg_acc) begin
            tbl_addr[cfg_idx] <= cfg_addr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            n_q         <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            write_valid <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            run_cycles  <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            write_valid <= wv_d;
            write_addr  <= wa_d;
            write_data  <= wd_d;
            done        <= done_d;
            timeout_err <= terr_d;
            run_cycles  <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        wv_d    = 1'b0;
        wa_d    = '0;
        wd_d    = '0;
        done_d  = 1'b0;
        terr_d  = timeout_err;
        run_d   = run_cycles;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    n_d    = n_sel;
                    idx_d  = '0;
                    wcnt_d = '0;
                    terr_d = 1'b0;
                    run_d  = '0;
                    if (n_sel != '0) begin
                        wv_d    = 1'b1;
                        wa_d    = entry0_addr;
                        wd_d    = entry0_data;
                        idx_d   = CNT_W'(1);
                        state_d = PROG;
                    end else begin
                        state_d = WAIT_BUSY;
                    end
                end
            end
            PROG: begin
                if (idx_q == n_q) begin
                    wcnt_d  = '0;
                    state_d = WAIT_BUSY;
                end else begin
                    wv_d  = 1'b1;
                    wa_d  = tbl_addr[idx_q[IDX_W-1:0]];
                    wd_d  = tbl_data[idx_q[IDX_W-1:0]];
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            WAIT_BUSY: begin
                // The cycle busy is first seen counts toward run_cycles.
                if (busy) begin
                    run_d   = CYC_W'(1);
                    state_d = RUN;
                end else if (wcnt_q == WAIT_LAST) begin
                    terr_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            RUN: begin
                if (busy) begin
                    if (run_cycles != '1) run_d = run_cycles + CYC_W'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end
endmodule

// File: tb/tb_vx_dcr_launch_ctrl.sv
// Scoreboard bench for vx_dcr_launch_ctrl: expected DCR writes queued at launch, popped on write_valid.
module tb_vx_dcr_launch_ctrl;
    localparam int AW = 12, DW = 32, NE = 8, TO = 32, CW = 32, IW = 3, NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_ready;
    logic          start;
    logic [NW-1:0] num_writes;
    logic          start_ready;
    logic          write_valid;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [CW-1:0] run_cycles;

    vx_dcr_launch_ctrl #(
        .DCR_ADDR_W(AW), .DCR_DATA_W(DW), .NUM_ENTRIES(NE), .TIMEOUT(TO), .CYC_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready),
        .start(start), .num_writes(num_writes), .start_ready(start_ready),
        .write_valid(write_valid), .write_addr(write_addr), .write_data(write_data),
        .busy(busy), .done(done), .timeout_err(timeout_err), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, wr_cnt = 0, first_wr_cyc = 0, done_cnt = 0, exp_done = 0, launch_cyc = 0;
    logic [63:0] sb [$];
    logic [AW-1:0] mdl_addr [NE];
    logic [DW-1:0] mdl_data [NE];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Write monitor: every issued write must match the head of the scoreboard.
    always @(negedge clk) begin
        logic extra;
        logic [63:0] e;
        if (write_valid) begin
            extra = (sb.size() == 0);
            chk("extra_write", {63'd0, extra}, 64'd0);
            if (!extra) begin
                e = sb.pop_front();
                chk("wr_pair", {20'd0, write_addr, write_data}, e);
            end
            if (wr_cnt == 0) first_wr_cyc = cyc;
            wr_cnt++;
        end else begin
            chk("idle_zero", {20'd0, write_addr, write_data}, 64'd0);
        end
        if (done) done_cnt++;
    end

    task automatic cfg_wr(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_valid = 1'b1;
        cfg_idx   = IW'(idx);
        cfg_addr  = a;
        cfg_data  = d;
        mdl_addr[idx] = a;
        mdl_data[idx] = d;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic launch(input int n);
        int m;
        m = (n > NE) ? NE : n;
        wr_cnt = 0;
        for (int i = 0; i < m; i++) sb.push_back({20'd0, mdl_addr[i], mdl_data[i]});
        start      = 1'b1;
        num_writes = NW'(n);
        exp_done++;
        @(posedge clk);
        #1 start = 1'b0;
        launch_cyc = cyc;
    endtask

    task automatic run_busy(input int k);
        busy = 1'b1;
        repeat (k) @(posedge clk);
        #1 busy = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic seen, output int dcyc);
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        @(negedge clk);
        chk("done_width", {63'd0, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int dcyc, dsnap;
        reset = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; num_writes = '0; busy = 1'b0;
        for (int i = 0; i < NE; i++) begin mdl_addr[i] = '0; mdl_data[i] = '0; end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        chk("rst_start_ready", {63'd0, start_ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_terr", {63'd0, timeout_err}, 64'd0);
        chk("rst_run", {32'd0, run_cycles}, 64'd0);

        // Three-entry program, busy for ten cycles.
        cfg_wr(0, 12'h001, 32'h8000_0000);
        cfg_wr(1, 12'h002, 32'h0000_0000);
        cfg_wr(2, 12'h003, 32'h0000_0001);
        launch(3);
        repeat (3) @(posedge clk);
        #1 run_busy(10);
        wait_done(100, seen, dcyc);
        chk("first_wr_lat", 64'(first_wr_cyc), 64'(launch_cyc));
        chk("wr_cnt3", 64'(wr_cnt), 64'd3);
        chk("sb_drain3", 64'(sb.size()), 64'd0);
        chk("run10", {32'd0, run_cycles}, 64'd10);
        chk("terr0", {63'd0, timeout_err}, 64'd0);

        // No writes, busy never rises.
        launch(0);
        wait_done(TO + 20, seen, dcyc);
        chk("to_latency", 64'(dcyc - launch_cyc), 64'(TO));
        chk("wr_cnt0", 64'(wr_cnt), 64'd0);
        chk("terr1", {63'd0, timeout_err}, 64'd1);
        chk("run0", {32'd0, run_cycles}, 64'd0);
        repeat (5) @(negedge clk);
        chk("terr_hold", {63'd0, timeout_err}, 64'd1);

        // Oversized request is clamped to the table depth.
        for (int i = 3; i < NE; i++) cfg_wr(i, AW'(12'h100 + i), DW'(32'h1111_1111 * i));
        launch(15);
        repeat (8) @(posedge clk);
        #1 run_busy(2);
        wait_done(100, seen, dcyc);
        chk("wr_cnt8", 64'(wr_cnt), 64'd8);
        chk("sb_drain8", 64'(sb.size()), 64'd0);
        chk("run2", {32'd0, run_cycles}, 64'd2);

        // cfg and start during RUN are ignored.
        launch(1);
        @(posedge clk);
        #1 busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cfg_valid = 1'b1; cfg_idx = '0; cfg_addr = 12'hFFF; cfg_data = 32'hDEAD_BEEF;
        start = 1'b1; num_writes = NW'(2);
        @(negedge clk);
        chk("run_cfg_ready", {63'd0, cfg_ready}, 64'd0);
        chk("run_start_ready", {63'd0, start_ready}, 64'd0);
        @(posedge clk);
        #1 cfg_valid = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 busy = 1'b0;
        wait_done(100, seen, dcyc);
        chk("run6", {32'd0, run_cycles}, 64'd6);
        repeat (5) @(negedge clk);
        chk("no_relaunch", 64'(wr_cnt), 64'd1);
        chk("idle_ready", {63'd0, start_ready}, 64'd1);
        launch(1);
        @(posedge clk);
        #1 run_busy(1);
        wait_done(100, seen, dcyc);
        chk("tbl_unchanged", 64'(sb.size()), 64'd0);

        // Reset after two of five writes.
        launch(5);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        dsnap = done_cnt;
        #1 reset = 1'b0;
        #1;
        chk("arst_wv", {63'd0, write_valid}, 64'd0);
        chk("arst_wdat", {20'd0, write_addr, write_data}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_run", {32'd0, run_cycles}, 64'd0);
        chk("arst_wr_cnt", 64'(wr_cnt), 64'd2);
        sb.delete();
        exp_done--;
        for (int i = 0; i < NE; i++) begin mdl_addr[i] = '0; mdl_data[i] = '0; end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rel_start_ready", {63'd0, start_ready}, 64'd1);
        chk("rel_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        chk("abort_no_done", 64'(done_cnt), 64'(dsnap));
        chk("abort_no_wr", 64'(wr_cnt), 64'd2);
        launch(2);
        wait_done(TO + 20, seen, dcyc);
        chk("tbl_cleared", 64'(sb.size()), 64'd0);
        chk("wr_cnt2", 64'(wr_cnt), 64'd2);

        // cfg write in the same cycle as start is used by that launch.
        cfg_valid = 1'b1; cfg_idx = '0; cfg_addr = 12'h010; cfg_data = 32'h0000_ABCD;
        mdl_addr[0] = 12'h010; mdl_data[0] = 32'h0000_ABCD;
        launch(1);
        cfg_valid = 1'b0;
        @(posedge clk);
        #1 run_busy(1);
        wait_done(100, seen, dcyc);
        chk("same_cyc_cfg", 64'(sb.size()), 64'd0);
        chk("wr_cnt1", 64'(wr_cnt), 64'd1);
        chk("done_total", 64'(done_cnt), 64'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vx_dcr_launch_ctrl.md
VX_DCR_LAUNCH_CTRL -- requirements
Module: vx_dcr_launch_ctrl

Interface
REQ-001 SHALL have parameter DCR_ADDR_W, default 12, DCR address width (matches VX_DCR_ADDR_WIDTH).
REQ-002 SHALL have parameter DCR_DATA_W, default 32, DCR data width (matches VX_DCR_DATA_WIDTH).
REQ-003 SHALL have parameter NUM_ENTRIES, default 8, launch-table depth; IDX_W = $clog2(NUM_ENTRIES), CNT_W = $clog2(NUM_ENTRIES+1).
REQ-004 SHALL have parameter TIMEOUT, default 1024, cycles allowed for busy to rise after the last DCR write.
REQ-005 SHALL have parameter CYC_W, default 32, run-cycle counter width.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-008 cfg_valid  in  1  table write strobe.
REQ-009 cfg_idx  in  IDX_W  table entry index.
REQ-010 cfg_addr  in  DCR_ADDR_W  DCR address for the entry.
REQ-011 cfg_data  in  DCR_DATA_W  DCR data for the entry.
REQ-012 cfg_ready  out  1  high only in IDLE; table write accepted when cfg_valid && cfg_ready.
REQ-013 start  in  1  launch request.
REQ-014 num_writes  in  CNT_W  number of table entries to issue, sampled on start acceptance.
REQ-015 start_ready  out  1  high only in IDLE; launch accepted when start && start_ready.
REQ-016 write_valid  out  1  DCR write strobe to the GPU top (no back-pressure).
REQ-017 write_addr  out  DCR_ADDR_W  DCR write address.
REQ-018 write_data  out  DCR_DATA_W  DCR write data.
REQ-019 busy  in  1  GPU busy status.
REQ-020 done  out  1  one-cycle pulse at launch completion.
REQ-021 timeout_err  out  1  sticky: busy never rose within TIMEOUT.
REQ-022 run_cycles  out  CYC_W  count of cycles busy was high in the last launch.

Function
REQ-023 SHALL implement FSM states IDLE, PROG, WAIT_BUSY, RUN, DONE; all outputs registered.
REQ-024 IDLE: accepted start captures n = min(num_writes, NUM_ENTRIES), clears timeout_err, run_cycles and the issue index; next state PROG if n>0, else WAIT_BUSY.
REQ-025 PROG: one DCR write per cycle, entries 0..n-1 in order; write_valid high exactly n consecutive cycles, first write the cycle after start acceptance; after entry n-1 next state WAIT_BUSY.
REQ-026 write_addr/write_data SHALL hold 0 whenever write_valid is low.
REQ-027 WAIT_BUSY: wait counter starts at 0 on entry, increments per cycle; busy=1 moves to RUN; counter reaching TIMEOUT-1 with busy=0 sets timeout_err=1 and moves to DONE.
REQ-028 RUN: run_cycles increments each cycle busy=1, saturating at all-ones; first cycle busy=0 moves to DONE.
REQ-029 DONE: done=1 for exactly that cycle; next state IDLE.
REQ-030 cfg writes accepted in IDLE only; cfg_valid outside IDLE is ignored without side effect.
REQ-031 cfg write and start accepted in the same cycle: write lands in the table and is visible to the PROG issued by that start.
REQ-032 start outside IDLE is ignored; it is not queued.
REQ-033 busy high during PROG SHALL NOT alter sequencing; it is only sampled in WAIT_BUSY and RUN.
REQ-034 run_cycles and timeout_err SHALL hold their values from DONE until the next start acceptance.

Reset
REQ-035 reset=0 SHALL immediately force state IDLE, write_valid=0, write_addr=0, write_data=0, done=0, timeout_err=0, run_cycles=0, all counters 0, all table entries 0.
REQ-036 reset asserted mid-PROG or mid-RUN SHALL abort with no further write_valid pulse and no done pulse.
REQ-037 cfg_ready and start_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-038 Load entries 0..2 = (0x001,0x80000000),(0x002,0x0),(0x003,0x1); start, num_writes=3 -> write_valid high 3 cycles from start+1 with those pairs in order; busy high 10 cycles -> done pulse, run_cycles=10, timeout_err=0.
REQ-039 start with num_writes=0 -> no write_valid; busy held 0 -> timeout_err=1 and done exactly TIMEOUT cycles after entering WAIT_BUSY.
REQ-040 num_writes=15 with NUM_ENTRIES=8 -> exactly 8 writes issued.
REQ-041 cfg_valid and start pulsed mid-RUN -> table unchanged, no relaunch, cfg_ready=start_ready=0.
REQ-042 reset pulled low during PROG after 2 of 5 writes -> outputs zero at once, table cleared, no done; after release start_ready=1.
REQ-043 cfg write idx=0 (0x010,0xABCD) in the same cycle as start, num_writes=1 -> issued write is (0x010,0xABCD).
